// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and the operation decode helper.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Returns {is_div, want_high_or_rem, op1_signed, op2_signed}.
    function automatic logic [3:0] md_decode(input logic [2:0] f);
        logic [3:0] d;
        case (f)
            MD_MUL:    d = 4'b0011;
            MD_MULH:   d = 4'b0111;
            MD_MULHSU: d = 4'b0110;
            MD_MULHU:  d = 4'b0100;
            MD_DIV:    d = 4'b1011;
            MD_DIVU:   d = 4'b1000;
            MD_REM:    d = 4'b1111;
            default:   d = 4'b1100;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, purely combinational.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one step per clock.
// Optional MULDIV_EARLY_OUT_EN lets divide-by-zero and signed overflow finish without iterating.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_want;
    logic             r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    logic [3:0]         w_dec;
    logic               w_s1;
    logic               w_s2;
    logic               w_div0;
    logic               w_neg_in;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_nxt_hi;
    logic [WIDTH-1:0]   w_nxt_lo;
    logic [2*WIDTH-1:0] w_fix_in;
    logic [2*WIDTH-1:0] w_fix_out;
    logic [WIDTH-1:0]   w_res;

    assign w_dec  = md_decode(i_funct3);
    assign w_s1   = w_dec[1] & i_op1[WIDTH-1];
    assign w_s2   = w_dec[0] & i_op2[WIDTH-1];
    assign w_div0 = (i_op2 == '0);
    // A zero divisor yields an all-ones quotient regardless of operand signs.
    assign w_neg_in = w_dec[3] ? (w_dec[2] ? w_s1 : ((w_s1 ^ w_s2) & ~w_div0))
                               : (w_s1 ^ w_s2);

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_op1 (.i_neg(w_s1), .i_val(i_op1), .o_val(w_mag1));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_op2 (.i_neg(w_s2), .i_val(i_op2), .o_val(w_mag2));

    // r_hi is accumulator/remainder, r_lo is multiplier/dividend shifting into product-low/quotient.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_opb};
    assign w_borrow = w_diff[WIDTH+1];

    always_comb begin
        w_nxt_hi = w_sum[WIDTH:1];
        w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_nxt_hi = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], ~w_borrow};
        end
    end

    // Sign fix-up works on the next-step values so the final result registers with the last step.
    assign w_fix_in = r_is_div ? {{WIDTH{1'b0}}, (r_want ? w_nxt_hi : w_nxt_lo)}
                               : {w_nxt_hi, w_nxt_lo};

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_res (.i_neg(r_neg), .i_val(w_fix_in), .o_val(w_fix_out));

    assign w_res = (!r_is_div && r_want) ? w_fix_out[2*WIDTH-1:WIDTH] : w_fix_out[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
    logic             w_ovf;
    logic [WIDTH-1:0] w_early;
    assign w_ovf   = w_dec[0] && (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_op2);
    assign w_early = w_div0 ? (w_dec[2] ? i_op1 : '1) : (w_dec[2] ? '0 : i_op1);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_want   <= 1'b0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_is_div <= w_dec[3];
                        r_want   <= w_dec[2];
                        r_neg    <= w_neg_in;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= w_mag1;
                        r_opb    <= w_mag2;
                        r_ready  <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_dec[3] && (w_div0 || w_ovf)) begin
                            r_state  <= DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_early;
                        end else begin
                            r_state  <= CALC;
                        end
`else
                        r_state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_hi  <= w_nxt_hi;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_res;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): results, strobe timing, busy behaviour and reset abort.
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        o_valid;
    logic [31:0] o_result;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Wait for the strobe; returns the cycle index relative to the accept cycle c0.
    task automatic wait_strobe(input int start, output int lat, output logic busy_ok);
        lat = start;
        busy_ok = 1'b1;
        while (o_valid !== 1'b1 && lat < 120) begin
            if (o_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (o_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic busy_ok;
        chk({tag, " ready_before"}, {31'b0, o_ready}, 32'd1);
        i_valid  = 1'b1;
        i_funct3 = f;
        i_op1    = a;
        i_op2    = b;
        tick();
        // Operand changes after accept must not matter.
        i_valid  = 1'b0;
        i_funct3 = ~f;
        i_op1    = $urandom;
        i_op2    = $urandom;
        wait_strobe(1, lat, busy_ok);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, o_result, exp_res);
        chk({tag, " busy_low"}, {31'b0, busy_ok}, 32'd1);
        tick();
        chk({tag, " strobe_one_cycle"}, {31'b0, o_valid}, 32'd0);
        chk({tag, " ready_after"}, {31'b0, o_ready}, 32'd1);
        chk({tag, " result_held"}, o_result, exp_res);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic seen;

        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_funct3 = 3'b000;
        i_op1    = '0;
        i_op2    = '0;
        repeat (3) tick();
        i_rst = 1'b0;

        chk("reset ready", {31'b0, o_ready}, 32'd1);
        chk("reset valid", {31'b0, o_valid}, 32'd0);
        chk("reset result", o_result, 32'h0);

        run_op("mul_neg",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh_minmin", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu_ones",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu_ones", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("div_neg",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_neg",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu_big",    3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
        run_op("remu_mod",    3'b111, 32'd100,      32'd7,        32'd2,        33);
        run_op("div_by0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT);
        run_op("div_neg_by0", 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPECIAL_LAT);
        run_op("remu_by0",    3'b111, 32'd5,        32'd0,        32'd5,        SPECIAL_LAT);
        run_op("rem_neg_by0", 3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPECIAL_LAT);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        SPECIAL_LAT);

        // Held request while busy is ignored, then taken back-to-back in c34.
        i_valid  = 1'b1;
        i_funct3 = 3'b000;
        i_op1    = 32'd6;
        i_op2    = 32'd7;
        tick();
        i_funct3 = 3'b101;
        i_op1    = 32'd100;
        i_op2    = 32'd7;
        wait_strobe(1, lat, busy_ok);
        chk("b2b first latency", 32'(lat), 32'd33);
        chk("b2b first result", o_result, 32'h2A);
        chk("b2b first busy_low", {31'b0, busy_ok}, 32'd1);
        tick();
        chk("b2b ready c34", {31'b0, o_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        wait_strobe(35, lat, busy_ok);
        chk("b2b second cycle", 32'(lat), 32'd67);
        chk("b2b second result", o_result, 32'hE);
        tick();

        // Reset during a divide aborts it without a strobe.
        i_valid  = 1'b1;
        i_funct3 = 3'b100;
        i_op1    = 32'd256;
        i_op2    = 32'd3;
        tick();
        i_valid = 1'b0;
        repeat (9) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort ready c11", {31'b0, o_ready}, 32'd1);
        chk("abort valid c11", {31'b0, o_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (o_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort no strobe", {31'b0, seen}, 32'd0);
        run_op("mul_after_abort", 3'b000, 32'd3, 32'd4, 32'h0000000C, 33);

        // Reset and request together: the request is dropped.
        i_rst    = 1'b1;
        i_valid  = 1'b1;
        i_funct3 = 3'b000;
        i_op1    = 32'd9;
        i_op2    = 32'd9;
        tick();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        chk("rst_wins ready", {31'b0, o_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (o_valid !== 1'b0) seen = 1'b1;
        end
        chk("rst_wins no strobe", {31'b0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Covers the M-extension operations: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Uses a radix-2 shift-add multiply and restoring divide, one step per clock.
- Connects to the hart through a valid/ready request and a single-cycle result strobe; the hart stalls until the strobe.

Parameters:
WIDTH, 32, operand/result width; any even value >= 8 is legal; iteration count equals WIDTH.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  request valid; accepted on an edge where i_valid && o_ready.
o_ready  output  1  unit idle and able to accept a request.
i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
i_op1  input  WIDTH  rs1 value: multiplicand or dividend.
i_op2  input  WIDTH  rs2 value: multiplier or divisor.
o_valid  output  1  one-cycle strobe; o_result is valid in this cycle.
o_result  output  WIDTH  result; held stable from o_valid until the next accept.

Behaviour:
- Reset: state IDLE, o_ready=1, o_valid=0, o_result=0, step counter=0, internal registers cleared.
- States and transitions:
  - IDLE -> CALC on accept. Latch funct3, take operand magnitudes, record the result sign.
  - CALC does one step per edge, counter 0..WIDTH-1. Moves to DONE after the WIDTH-th step.
  - DONE -> IDLE unconditionally.
- o_ready = (state==IDLE). o_valid = (state==DONE). There is no output back-pressure.
- Latency: accept in cycle c0, o_valid in cycle c(WIDTH+1), which is c33 for WIDTH=32. Next accept is possible in c(WIDTH+2).
- Requests while busy: i_valid when o_ready=0 is ignored. Operand and funct3 changes after accept have no effect.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitude = conditional two's-complement negate.
- Multiply:
  - 2*WIDTH-bit unsigned product of the magnitudes; negated in DONE if the signs differ.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide:
  - Restoring divide on magnitudes; quotient truncates toward zero.
  - Quotient negated if the operand signs differ. Remainder takes the sign of the dividend.
- Special cases follow RISC-V exactly:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give op1.
  - Signed overflow (op1 = most-negative, op2 = -1): DIV gives op1, REM gives 0.
- Reset mid-operation: the next cycle is IDLE with o_ready=1 and o_valid=0. The aborted op never strobes.
- Simultaneous i_rst and i_valid: reset wins and the request is dropped.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow requests skip CALC and go IDLE->DONE, so o_valid appears in c1.
- Not defined: all requests take the full WIDTH+1 cycles.
- Result values are identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 localparams: MD_MUL .. MD_REMU.
  - state enum: IDLE, CALC, DONE.
  - a decode helper returning {is_div, want_high_or_rem, op1_signed, op2_signed}.
- One sub-module, muldiv_negate: WIDTH-parameterised conditional two's-complement negate. It is instantiated for operand conditioning and result fix-up.

Test Plan:
1. MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB; o_valid exactly in c33 for one cycle; o_ready low c1..c33.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
4. DIV 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
   - o_valid in c1 with MULDIV_EARLY_OUT_EN defined, c33 without.
5. Hold i_valid with new operands throughout busy -> ignored. Back-to-back: second op accepted in c34 and completes in c67 with a correct result.
6. Assert i_rst in c10 of a DIV -> c11 shows o_ready=1, o_valid=0; no later strobe; a following MUL 3 x 4 returns 0x0000000C.
